// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types and defaults for the EX-stage hazard/forwarding unit
//
// Purpose: forwarding source codes, FSM state encoding and default widths.
// Ports: none (package).
// Build option: FWD_ZERO_REG_EN (consumed by hazard_forward_unit).

package fwd_pkg;

  localparam int FWD_REG_ADDR_W = 5;
  localparam int FWD_VLEN       = 128;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2,
    FWD_HOLD = 2'd3
  } fwd_src_e;

  typedef enum logic {
    RUN    = 1'b0,
    LSTALL = 1'b1
  } fwd_state_e;

endpackage

// File: rtl/fwd_operand_mux.sv
// rtl/fwd_operand_mux.sv - per-operand forwarding priority select
//
// Purpose: picks the forwarding source for one EX source operand.
//          Priority MEM ALU > WB > load hold register > none.
// Ports:
//   live_i        operand is real and read this cycle
//   rs_i          operand source address
//   mem_fwd_i     MEM carries a forwardable ALU write
//   rd_mem_i      MEM destination, result_mem_i its data
//   wb_fwd_i      WB writes a register
//   rd_wb_i       WB destination, result_wb_i its data
//   hold_valid_i  hold register holds captured load data
//   hold_rd_i     hold register destination, hold_data_i its data
//   mem_match_o   operand address matches MEM destination (used for load-use)
//   fwd_en_o      operand is forwarded
//   fwd_src_o     forwarding source code (fwd_src_e)
//   fwd_data_o    forwarded data, zero when not forwarded

module fwd_operand_mux
  import fwd_pkg::*;
#(
  parameter int REG_ADDR_W = FWD_REG_ADDR_W,
  parameter int VLEN       = FWD_VLEN
) (
  input  logic                  live_i,
  input  logic [REG_ADDR_W-1:0] rs_i,
  input  logic                  mem_fwd_i,
  input  logic [REG_ADDR_W-1:0] rd_mem_i,
  input  logic [VLEN-1:0]       result_mem_i,
  input  logic                  wb_fwd_i,
  input  logic [REG_ADDR_W-1:0] rd_wb_i,
  input  logic [VLEN-1:0]       result_wb_i,
  input  logic                  hold_valid_i,
  input  logic [REG_ADDR_W-1:0] hold_rd_i,
  input  logic [VLEN-1:0]       hold_data_i,
  output logic                  mem_match_o,
  output logic                  fwd_en_o,
  output logic [1:0]            fwd_src_o,
  output logic [VLEN-1:0]       fwd_data_o
);

  logic wb_match;
  logic hold_match;

  always_comb begin
    mem_match_o = live_i & (rs_i == rd_mem_i);
    wb_match    = live_i & (rs_i == rd_wb_i);
    hold_match  = live_i & (rs_i == hold_rd_i);
  end

  always_comb begin
    fwd_en_o   = 1'b0;
    fwd_src_o  = FWD_NONE;
    fwd_data_o = '0;
    if (mem_fwd_i && mem_match_o) begin
      fwd_en_o   = 1'b1;
      fwd_src_o  = FWD_MEM;
      fwd_data_o = result_mem_i;
    end else if (wb_fwd_i && wb_match) begin
      fwd_en_o   = 1'b1;
      fwd_src_o  = FWD_WB;
      fwd_data_o = result_wb_i;
    end else if (hold_valid_i && hold_match) begin
      fwd_en_o   = 1'b1;
      fwd_src_o  = FWD_HOLD;
      fwd_data_o = hold_data_i;
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// rtl/hazard_forward_unit.sv - EX-stage RAW forwarding and multi-cycle load-use stall
//
// Purpose: resolves NUM_SRC EX operands against MEM, WB and a load hold
//          register; stalls LOAD_LATENCY cycles on a load-use hazard.
// Build option: FWD_ZERO_REG_EN makes register 0 hardwired zero (never
//               forwarded, never stalls, never captured).
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   flush         kills pending stall and hold data
//   valid_ex      EX holds a real instruction
//   rs_ex         packed EX source addresses, rs_used_ex per-operand read enable
//   we_mem, alu_mem, rd_mem, result_mem   MEM write info (alu_mem=0 means load)
//   we_wb, rd_wb, result_wb               WB write info
//   stall         freeze IF/ID/EX, bubble into MEM
//   fwd_en, fwd_src, fwd_data             packed per-operand forwarding outputs

module hazard_forward_unit
  import fwd_pkg::*;
#(
  parameter int NUM_SRC      = 2,
  parameter int REG_ADDR_W   = FWD_REG_ADDR_W,
  parameter int VLEN         = FWD_VLEN,
  parameter int LOAD_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          valid_ex,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] rs_ex,
  input  logic [NUM_SRC-1:0]            rs_used_ex,
  input  logic                          we_mem,
  input  logic                          alu_mem,
  input  logic [REG_ADDR_W-1:0]         rd_mem,
  input  logic [VLEN-1:0]               result_mem,
  input  logic                          we_wb,
  input  logic [REG_ADDR_W-1:0]         rd_wb,
  input  logic [VLEN-1:0]               result_wb,
  output logic                          stall,
  output logic [NUM_SRC-1:0]            fwd_en,
  output logic [NUM_SRC*2-1:0]          fwd_src,
  output logic [NUM_SRC*VLEN-1:0]       fwd_data
);

  localparam int              CNT_W    = 3;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_LATENCY - 1);

  fwd_state_e              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [REG_ADDR_W-1:0]   pend_rd_q, pend_rd_d;
  logic                    hold_valid_q, hold_valid_d;
  logic [REG_ADDR_W-1:0]   hold_rd_q, hold_rd_d;
  logic [VLEN-1:0]         hold_data_q, hold_data_d;

  logic                    ex_live;
  logic                    mem_wr;
  logic                    wb_wr;
  logic                    mem_alu_fwd;
  logic                    mem_load;
  logic [NUM_SRC-1:0]      mem_match;
  logic                    load_use;
  logic                    detect_en;
  logic                    stall_raw;
  logic                    capture;

  // Reset masks the operand matches so all forwarding outputs read zero.
  assign ex_live = valid_ex & ~rst;

`ifdef FWD_ZERO_REG_EN
  assign mem_wr = we_mem & (rd_mem != '0);
  assign wb_wr  = we_wb & (rd_wb != '0);
`else
  assign mem_wr = we_mem;
  assign wb_wr  = we_wb;
`endif

  assign mem_alu_fwd = mem_wr & alu_mem;
  assign mem_load    = mem_wr & ~alu_mem;

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_op
    fwd_operand_mux #(
      .REG_ADDR_W (REG_ADDR_W),
      .VLEN       (VLEN)
    ) u_mux (
      .live_i       (ex_live & rs_used_ex[gi]),
      .rs_i         (rs_ex[gi*REG_ADDR_W +: REG_ADDR_W]),
      .mem_fwd_i    (mem_alu_fwd),
      .rd_mem_i     (rd_mem),
      .result_mem_i (result_mem),
      .wb_fwd_i     (wb_wr),
      .rd_wb_i      (rd_wb),
      .result_wb_i  (result_wb),
      .hold_valid_i (hold_valid_q),
      .hold_rd_i    (hold_rd_q),
      .hold_data_i  (hold_data_q),
      .mem_match_o  (mem_match[gi]),
      .fwd_en_o     (fwd_en[gi]),
      .fwd_src_o    (fwd_src[gi*2 +: 2]),
      .fwd_data_o   (fwd_data[gi*VLEN +: VLEN])
    );
  end

  // A running stall (cnt != 0) already covers the pending load, so new
  // detection waits until the countdown has drained.
  assign load_use  = mem_load & (|mem_match);
  assign detect_en = (state_q == RUN) || (cnt_q == '0);
  assign stall_raw = ((state_q == LSTALL) && (cnt_q != '0)) || (detect_en && load_use);
  assign stall     = stall_raw & ~rst & ~flush;

  // The load reaches WB while EX is frozen; grab its result so the stalled
  // consumer still sees it after WB has moved on.
  assign capture = (stall || (state_q == LSTALL)) && wb_wr && (rd_wb == pend_rd_q);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_rd_d    = pend_rd_q;
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_data_d  = hold_data_q;

    if (detect_en && load_use) begin
      state_d   = LSTALL;
      cnt_d     = CNT_INIT;
      pend_rd_d = rd_mem;
    end else if (state_q == LSTALL) begin
      if (cnt_q == '0) begin
        state_d = RUN;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    // Capture wins over the advance-clear in the same cycle.
    if (capture) begin
      hold_valid_d = 1'b1;
      hold_rd_d    = pend_rd_q;
      hold_data_d  = result_wb;
    end else if (valid_ex && !stall) begin
      hold_valid_d = 1'b0;
    end

    if (flush) begin
      state_d      = RUN;
      cnt_d        = '0;
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      cnt_q        <= '0;
      pend_rd_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_rd_q    <= pend_rd_d;
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_data_q  <= hold_data_d;
    end
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the scalar/vector forwarding unit in the execute stage.
- Resolves RAW hazards for NUM_SRC source operands of the EX instruction, each resolved independently.
- Forwarding sources: MEM ALU result, WB result, and a load holding register.
- Inserts multi-cycle load-use stalls sized by LOAD_LATENCY through a small FSM.

Parameters:
- NUM_SRC, 2, number of EX source operands resolved (1..4).
- REG_ADDR_W, 5, register address width.
- VLEN, 128, forwarded data width; scalar consumers use bits [31:0].
- LOAD_LATENCY, 1, stall cycles per load-use hazard (1..7).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  pipeline flush; kills pending stall and hold data
- valid_ex  in  1  EX holds a real instruction
- rs_ex  in  NUM_SRC*REG_ADDR_W  EX source addresses, operand i at [i*REG_ADDR_W +: REG_ADDR_W]
- rs_used_ex  in  NUM_SRC  operand i actually read
- we_mem  in  1  MEM instruction writes rd
- alu_mem  in  1  1 = MEM result from ALU (forwardable), 0 = load (not yet available)
- rd_mem  in  REG_ADDR_W  MEM destination
- result_mem  in  VLEN  MEM ALU result
- we_wb  in  1  WB instruction writes rd
- rd_wb  in  REG_ADDR_W  WB destination
- result_wb  in  VLEN  WB result
- stall  out  1  freeze IF/ID/EX, bubble into MEM
- fwd_en  out  NUM_SRC  operand i is forwarded
- fwd_src  out  NUM_SRC*2  per-operand source code
- fwd_data  out  NUM_SRC*VLEN  per-operand forwarded data

Behaviour:
- Match(i, rd) = valid_ex & rs_used_ex[i] & (rs_ex[i] == rd).
- Per-operand priority: MEM (we_mem & alu_mem & match) > WB (we_wb & match) > HOLD (hold_valid & match hold_rd) > NONE.
- When no source matches: fwd_en[i]=0, fwd_src[i]=NONE, fwd_data[i]=0. Outputs are never driven to high impedance.
- All operands may forward at the same time, including from the same source.
- FSM states: RUN, LSTALL.
  - RUN, load-use hazard (we_mem & !alu_mem & any Match(i, rd_mem)):
    - stall=1 in the same cycle (combinational).
    - Next cycle: state LSTALL, pend_rd<=rd_mem, cnt<=LOAD_LATENCY-1.
  - RUN, no hazard: stall=0.
  - LSTALL: stall = (cnt != 0). cnt decrements each cycle. At cnt==0, stall=0 and state returns to RUN.
  - LOAD_LATENCY=1: LSTALL lasts one cycle with stall=0 and is effectively transparent.
- Total stall length: exactly LOAD_LATENCY cycles per hazard.
- Hold register:
  - In any cycle with stall=1 or state LSTALL, and we_wb & rd_wb==pend_rd: capture hold_data<=result_wb, hold_rd<=pend_rd, hold_valid<=1.
  - Cleared when the EX instruction advances (valid_ex & !stall) unless recaptured in that same cycle; capture wins.
- Load-use detection is suppressed in LSTALL while cnt != 0; re-evaluated normally in RUN.
- flush: next cycle state=RUN, cnt=0, hold_valid=0. stall is forced 0 in the flush cycle.
- Reset (sync): state=RUN, cnt=0, pend_rd=0, hold_valid=0, hold_rd=0, hold_data=0. While rst=1: stall=0, fwd_en=0, fwd_src=NONE, fwd_data=0. Reset mid-stall aborts the stall.
- Latency: forwarding paths are combinational. Only the FSM, counter and hold register are registered.

Optional Feature:
- Macro: FWD_ZERO_REG_EN.
- Defined: register address 0 is hardwired zero. Writes to rd=0 never forward, never trigger load-use stalls, and are never captured.
- Undefined: address 0 is treated like any other register.

Decomposition:
- Package fwd_pkg:
  - fwd_src_e enum: FWD_NONE=0, FWD_MEM=1, FWD_WB=2, FWD_HOLD=3.
  - fwd_state_e enum: RUN, LSTALL.
  - Default REG_ADDR_W and VLEN constants.
- Sub-module fwd_operand_mux: one per operand via generate. Performs the per-operand priority select and drives fwd_en/fwd_src/fwd_data.
- FSM, counter and hold register live in the top module.

Test Plan:
- MEM ALU and WB both write x3; EX rs0=rs1=x3, result_mem=0xA, result_wb=0xB -> both operands FWD_MEM, data 0xA, stall=0.
- rs0=x4 matches MEM ALU (0x11), rs1=x5 matches WB (0x22) -> operand0 MEM 0x11, operand1 WB 0x22 simultaneously.
- LOAD_LATENCY=3, MEM load rd=x7, EX rs1=x7 -> stall high exactly 3 cycles. WB writes x7=0xDEAD during the stall -> after release, operand1 FWD_HOLD 0xDEAD; hold_valid clears once EX advances.
- LOAD_LATENCY=1, load x2 in MEM, EX uses x2 -> stall 1 cycle. Next cycle WB x2=0x55 -> FWD_WB 0x55, stall=0.
- rst or flush asserted during the second cycle of a 3-cycle stall -> next cycle stall=0, state RUN, hold_valid=0, no stale forward.
- FWD_ZERO_REG_EN defined: MEM load with rd=x0, EX rs0=x0 -> no stall, fwd_en=0, fwd_data=0.
